// File: rtl/bg_band_filler.sv
`timescale 1ns/1ps
// Background compositor: replaces transparent palette indices with a per-band solid colour
// or a scrolled, tiled pattern texel. Two-stage pipeline, no stalls.
module bg_band_filler #(
   parameter int unsigned INDEX_W     = 9,
   parameter int unsigned COORD_W     = 10,
   parameter int unsigned NUM_BANDS   = 4,
   parameter int unsigned TRANSP_BITS = 4,
   parameter int unsigned TILE_W_LOG2 = 6,
   parameter int unsigned TILE_H_LOG2 = 5,
   parameter int unsigned PAT_BITS    = 3
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               enable,
   input  logic                               in_valid,
   input  logic [INDEX_W-1:0]                 index_in,
   input  logic [COORD_W-1:0]                 x,
   input  logic [COORD_W-1:0]                 y,
   output logic                               out_valid,
   output logic [INDEX_W-1:0]                 index_out,
   input  logic                               cfg_we,
   input  logic [4:0]                         cfg_addr,
   input  logic [COORD_W+INDEX_W:0]           cfg_data,
   input  logic                               pat_we,
   input  logic [TILE_W_LOG2+TILE_H_LOG2-1:0] pat_addr,
   input  logic [PAT_BITS-1:0]                pat_data
);

   localparam int unsigned PAT_A_W   = TILE_W_LOG2 + TILE_H_LOG2;
   localparam int unsigned PAT_DEPTH = 2 ** PAT_A_W;

   logic [COORD_W-1:0]  end_q    [NUM_BANDS];
   logic [NUM_BANDS-1:0] mode_q;
   logic [INDEX_W-1:0]  color_q  [NUM_BANDS];
   logic [COORD_W-1:0]  scroll_q [NUM_BANDS];
   logic [INDEX_W-1:0]  default_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANDS; b++) begin
            end_q[b]    <= (b == 0) ? COORD_W'(300) :
                           (b == 1) ? COORD_W'(400) : {COORD_W{1'b1}};
            mode_q[b]   <= (b == 1);
            color_q[b]  <= (b < 2) ? '0 : INDEX_W'(7);
            scroll_q[b] <= '0;
         end
         default_q <= INDEX_W'(7);
      end else if (cfg_we) begin
         for (int b = 0; b < NUM_BANDS; b++) begin
            if (cfg_addr == 5'(b)) end_q[b] <= cfg_data[COORD_W-1:0];
            if (cfg_addr == 5'(NUM_BANDS + b)) begin
               mode_q[b]  <= cfg_data[INDEX_W];
               color_q[b] <= cfg_data[INDEX_W-1:0];
            end
            if (cfg_addr == 5'(2 * NUM_BANDS + b)) scroll_q[b] <= cfg_data[COORD_W-1:0];
         end
         if (cfg_addr == 5'(3 * NUM_BANDS)) default_q <= cfg_data[INDEX_W-1:0];
      end
   end

   // Band select: walk from the highest band down so the lowest matching band wins.
   logic [COORD_W-1:0] start_w [NUM_BANDS];
   logic               sel_mode;
   logic [INDEX_W-1:0] sel_color;
   logic [COORD_W-1:0] sel_start;
   logic [COORD_W-1:0] sel_scroll;
   logic [COORD_W-1:0] row_full;
   logic [COORD_W-1:0] col_full;
   logic [PAT_A_W-1:0] rd_addr;

   always_comb begin
      start_w[0] = '0;
      for (int b = 1; b < NUM_BANDS; b++) start_w[b] = end_q[b-1];
      sel_mode   = 1'b0;
      sel_color  = default_q;
      sel_start  = '0;
      sel_scroll = '0;
      for (int b = NUM_BANDS - 1; b >= 0; b--) begin
         if (y < end_q[b]) begin
            sel_mode   = mode_q[b];
            sel_color  = color_q[b];
            sel_start  = start_w[b];
            sel_scroll = scroll_q[b];
         end
      end
      row_full = y - sel_start;
      col_full = x + sel_scroll;
      rd_addr  = {row_full[TILE_H_LOG2-1:0], col_full[TILE_W_LOG2-1:0]};
   end

   // Not reset: contents are only meaningful once software has written them.
   logic [PAT_BITS-1:0] pat_mem [PAT_DEPTH];

   always_ff @(posedge clk) begin
      if (pat_we) pat_mem[pat_addr] <= pat_data;
   end

   logic                valid1_q;
   logic                en1_q;
   logic [INDEX_W-1:0]  idx1_q;
   logic                mode1_q;
   logic [INDEX_W-1:0]  color1_q;
   logic [PAT_BITS-1:0] texel_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid1_q <= 1'b0;
         en1_q    <= 1'b0;
         idx1_q   <= '0;
         mode1_q  <= 1'b0;
         color1_q <= '0;
         texel_q  <= '0;
      end else begin
         valid1_q <= in_valid;
         if (in_valid) begin
            en1_q    <= enable;
            idx1_q   <= index_in;
            mode1_q  <= sel_mode;
            color1_q <= sel_color;
            texel_q  <= pat_mem[rd_addr];
         end
      end
   end

   logic               transp_w;
   logic [INDEX_W-1:0] result_w;

   always_comb begin
      transp_w = (idx1_q[TRANSP_BITS-1:0] == '0);
      result_w = idx1_q;
      if (en1_q && transp_w) begin
         result_w = mode1_q ? color1_q + INDEX_W'(texel_q) : color1_q;
      end
   end

   logic               out_valid_q;
   logic [INDEX_W-1:0] index_out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         index_out_q <= '0;
      end else begin
         out_valid_q <= valid1_q;
         if (valid1_q) index_out_q <= result_w;
      end
   end

   assign out_valid = out_valid_q;
   assign index_out = index_out_q;

endmodule

// File: tb/tb_bg_band_filler.sv
`timescale 1ns/1ps
// Bench for bg_band_filler: hand-derived vectors, directed corner sequences, and a random
// stream checked against a behavioural model of the band/pattern rules.
module tb_bg_band_filler;

   localparam int NB = 4;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        in_valid;
   logic [8:0]  index_in;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        out_valid;
   logic [8:0]  index_out;
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [19:0] cfg_data;
   logic        pat_we;
   logic [10:0] pat_addr;
   logic [2:0]  pat_data;

   bg_band_filler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .in_valid  (in_valid),
      .index_in  (index_in),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .index_out (index_out),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .pat_we    (pat_we),
      .pat_addr  (pat_addr),
      .pat_data  (pat_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model state
   int m_end [NB];
   int m_mode [NB];
   int m_color [NB];
   int m_scroll [NB];
   int m_default;
   int m_pat [2048];

   function automatic void model_reset();
      m_end[0] = 300; m_end[1] = 400; m_end[2] = 1023; m_end[3] = 1023;
      for (int b = 0; b < NB; b++) begin
         m_mode[b]   = (b == 1) ? 1 : 0;
         m_color[b]  = (b < 2) ? 0 : 7;
         m_scroll[b] = 0;
      end
      m_default = 7;
   endfunction

   function automatic void model_cfg(input int a, input int d);
      if (a < NB) m_end[a] = d % 1024;
      else if (a < 2 * NB) begin
         m_mode[a - NB]  = (d >> 9) & 1;
         m_color[a - NB] = d % 512;
      end else if (a < 3 * NB) m_scroll[a - 2 * NB] = d % 1024;
      else if (a == 3 * NB) m_default = d % 512;
   endfunction

   function automatic int model(input int xx, input int yy, input int idx, input bit en);
      if (!en || (idx % 16) != 0) return idx;
      for (int b = 0; b < NB; b++) begin
         if (yy < m_end[b]) begin
            int st;
            int row;
            int col;
            st  = (b == 0) ? 0 : m_end[b-1];
            row = ((yy - st + 1024) % 1024) % 32;
            col = ((xx + m_scroll[b]) % 1024) % 64;
            if (m_mode[b] != 0) return (m_color[b] + m_pat[row * 64 + col]) % 512;
            return m_color[b];
         end
      end
      return m_default;
   endfunction

   typedef struct {
      int    exp;
      string name;
   } exp_t;
   exp_t expq[$];

   // One clock: queue the expected result using the config as it stands before the edge,
   // then apply this cycle's writes to the model.
   task automatic tick(input bit use_exp, input int exp, input string name);
      exp_t e;
      if (in_valid) begin
         e.exp  = use_exp ? exp : model(int'(x), int'(y), int'(index_in), enable);
         e.name = name;
         expq.push_back(e);
      end
      if (cfg_we) model_cfg(int'(cfg_addr), int'(cfg_data));
      if (pat_we) m_pat[pat_addr] = int'(pat_data);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      pat_we   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, "");
   endtask

   task automatic pixel(input int xx, input int yy, input int idx, input int exp,
                        input string name);
      in_valid = 1'b1;
      x        = 10'(xx);
      y        = 10'(yy);
      index_in = 9'(idx);
      tick(1'b1, exp, name);
   endtask

   task automatic cfg(input int a, input int d);
      cfg_we   = 1'b1;
      cfg_addr = 5'(a);
      cfg_data = 20'(d);
      tick(1'b0, 0, "");
   endtask

   // Output monitor: out_valid must equal in_valid two edges earlier; index_out must hold
   // between valid outputs.
   bit vh1 = 0;
   bit vh2 = 0;
   int last_exp = 0;

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (rst_n) begin
            vh2 = vh1;
            vh1 = in_valid;
         end
         @(negedge clk);
         if (!rst_n) begin
            vh1 = 0;
            vh2 = 0;
            last_exp = 0;
            expq.delete();
         end else begin
            check("out_valid_delay2", 32'(out_valid), 32'(vh2));
            if (vh2) begin
               if (expq.size() == 0) begin
                  check("expected_queue_underflow", 32'(expq.size()), 32'd1);
               end else begin
                  e = expq.pop_front();
                  check(e.name, 32'(index_out), 32'(e.exp));
                  last_exp = e.exp;
               end
            end else begin
               check("index_hold_on_bubble", 32'(index_out), 32'(last_exp));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int    x;
      int    y;
      int    idx;
      bit    en;
      int    exp;
      string name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vec_t v;
      rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; index_in = '0; x = '0; y = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; pat_we = 1'b0; pat_addr = '0; pat_data = '0;
      model_reset();
      for (int i = 0; i < 2048; i++) m_pat[i] = 0;

      vecs.push_back('{0,   299,  'h010, 1'b1, 'h000, "reset_band0_solid"});
      vecs.push_back('{0,   400,  'h010, 1'b1, 'h007, "reset_band2_solid"});
      vecs.push_back('{0,   1023, 'h010, 1'b1, 'h007, "reset_default"});
      vecs.push_back('{0,   50,   'h123, 1'b1, 'h123, "opaque_passthrough"});
      vecs.push_back('{0,   50,   'h010, 1'b0, 'h010, "bypass_enable0"});
      vecs.push_back('{5,   200,  'h1F0, 1'b1, 'h000, "transparent_high_bits"});
      vecs.push_back('{9,   0,    'h001, 1'b1, 'h001, "opaque_lsb"});
      vecs.push_back('{100, 450,  'h000, 1'b1, 'h007, "band2_zero_index"});

      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_index_out", 32'(index_out), 32'd0);
      rst_n = 1'b1;

      for (int a = 0; a < 2048; a++) begin
         pat_we = 1'b1; pat_addr = 11'(a); pat_data = 3'($urandom);
         tick(1'b0, 0, "");
      end
      pat_we = 1'b1; pat_addr = 11'(3 * 64 + 5); pat_data = 3'd6; tick(1'b0, 0, "");
      pat_we = 1'b1; pat_addr = 11'(18 * 64);    pat_data = 3'd5; tick(1'b0, 0, "");

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         enable = v.en;
         pixel(v.x, v.y, v.idx, v.exp, v.name);
      end
      enable = 1'b1;
      idle(3);

      // Pattern band with scroll, including scroll wrap-around
      cfg(NB + 1, 'h220);
      cfg(2 * NB + 1, 1);
      pixel(4, 303, 'h010, 'h026, "pattern_scroll1");
      cfg(2 * NB + 1, 1023);
      pixel(6, 303, 'h010, 'h026, "pattern_scroll_wrap");

      // Config write and pixel on the same edge: pixel still sees the old END[0]
      cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 20'd500;
      pixel(1, 350, 'h020, 'h025, "same_edge_old_end");
      pixel(1, 350, 'h020, 'h000, "next_edge_new_end");
      idle(3);

      // Random configuration then a random stream with bubbles and live writes
      for (int i = 0; i < 6; i++) cfg($urandom_range(0, 15), $urandom);
      for (int i = 0; i < 64; i++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         x        = 10'($urandom);
         y        = 10'($urandom);
         index_in = ($urandom_range(0, 1) == 0) ? 9'($urandom) & 9'h1F0 : 9'($urandom);
         enable   = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 7) == 0) begin
            cfg_we = 1'b1; cfg_addr = 5'($urandom_range(0, 15)); cfg_data = 20'($urandom);
         end
         if ($urandom_range(0, 7) == 0) begin
            pat_we = 1'b1; pat_addr = 11'($urandom); pat_data = 3'($urandom);
            if (pat_addr == 11'(18 * 64)) pat_addr = 11'(18 * 64 + 1);
         end
         tick(1'b0, 0, "random_stream");
      end
      enable = 1'b1;
      idle(3);

      // Mid-stream reset with both stages occupied
      pixel(0, 0, 'h155, 'h155, "pre_reset_a");
      pixel(0, 0, 'h0AB, 'h0AB, "pre_reset_b");
      check("pre_reset_out_valid", 32'(out_valid), 32'd1);
      check("pre_reset_index_out", 32'(index_out), 32'h155);
      rst_n = 1'b0;
      #1;
      check("async_reset_out_valid", 32'(out_valid), 32'd0);
      check("async_reset_index_out", 32'(index_out), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      idle(3);
      pixel(0, 350, 'h010, 'h005, "post_reset_end0_300");
      idle(4);
      check("queue_drained", 32'(expq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bg_band_filler.md
# bg_band_filler

Parametrised background compositor for the GPU pixel pipeline. It sits after sprite/tile composition and before the palette lookup. Every transparent palette index is replaced with a background index chosen by the pixel's horizontal band. A band is either a solid colour or a tiled, scrollable pattern read from a small writable pattern memory, which covers grass-style textured bands. Band layout, colours, scroll and patterns are all runtime-configurable.

## Interface
Parameters:
- INDEX_W, 9, palette index width
- COORD_W, 10, x/y coordinate width
- NUM_BANDS, 4, number of programmable bands (2..8)
- TRANSP_BITS, 4, index is transparent when index_in[TRANSP_BITS-1:0] == 0
- TILE_W_LOG2, 6, pattern tile width = 2^TILE_W_LOG2 pixels
- TILE_H_LOG2, 5, pattern tile height = 2^TILE_H_LOG2 lines
- PAT_BITS, 3, bits per pattern texel

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  0 = bypass (index passed unchanged, same latency)
- in_valid  in  1  pixel qualifier
- index_in  in  INDEX_W  composited palette index
- x, y  in  COORD_W each  pixel coordinate, sampled with in_valid
- out_valid  out  1  output qualifier
- index_out  out  INDEX_W  final palette index
- cfg_we  in  1  register write strobe
- cfg_addr  in  5  register address
- cfg_data  in  COORD_W+INDEX_W+1  write data, LSB-aligned
- pat_we  in  1  pattern memory write strobe
- pat_addr  in  TILE_W_LOG2+TILE_H_LOG2  texel address {row, col}
- pat_data  in  PAT_BITS  texel value

## Operation
- Register map, where b = 0..NUM_BANDS-1:
  - addr b: END[b] (COORD_W). Band b covers y < END[b].
  - addr NUM_BANDS+b: CTRL[b] = {MODE, COLOR[INDEX_W-1:0]}. MODE 0 = solid, 1 = pattern.
  - addr 2*NUM_BANDS+b: SCROLL[b] (COORD_W).
  - addr 3*NUM_BANDS: DEFAULT colour (INDEX_W).
  - Unmapped addresses are ignored. Data bits above a register's width are ignored.
- Reset values:
  - END[0]=300, END[1]=400, END[2..]=2^COORD_W-1.
  - CTRL[0]={0,0}, CTRL[1]={1,0}, CTRL[2]={0,7}, CTRL[3..]={0,7}.
  - SCROLL=0, DEFAULT=7.
  - Pattern memory is not cleared by reset. Its contents are undefined until written.
- Band select:
  - The lowest b with y < END[b] wins, so non-monotonic END values are legal and resolve by priority.
  - If no band matches, the pixel uses DEFAULT in solid mode.
- START[b] = END[b-1], with START[0] = 0.
- Pattern address:
  - row = (y - START[b]) mod 2^TILE_H_LOG2.
  - col = (x + SCROLL[b]) mod 2^TILE_W_LOG2.
  - All arithmetic is modulo 2^COORD_W. Only the low bits are used, so wrap-around is free.
- Output rules:
  - enable = 0, or index_in not transparent: index_out = index_in.
  - Transparent pixel, solid band: index_out = COLOR[b].
  - Transparent pixel, pattern band: index_out = COLOR[b] + texel, zero-extended, truncated to INDEX_W (wraps).
- Pattern memory:
  - Synchronous single-read, single-write.
  - A simultaneous write and read of the same address returns the old texel (read-first).

## Timing
- Fixed 2-cycle latency from in_valid to out_valid, with no stalls and no backpressure. in_valid may be high every cycle.
- Stage 1 registers:
  - the band-select result, pattern address and mode/colour snapshot;
  - the pattern memory read is issued in this stage.
- Stage 2 registers index_out and out_valid.
- Bubbles:
  - in_valid = 0 produces out_valid = 0 two cycles later.
  - index_out holds its last value during a bubble.
- Config timing:
  - A cfg_we write at edge N takes effect for pixels sampled at edge N+1 or later.
  - A pixel already in stage 1 uses the snapshot taken at its stage-1 edge.
- Pattern timing: a pat_we write at edge N is readable by pixels sampled at edge N+1 or later.
- enable is sampled alongside the pixel at stage 1 and travels down the pipeline with it.
- Reset, including assertion mid-frame:
  - out_valid = 0 and index_out = 0 immediately (asynchronous);
  - the pipeline is flushed and all registers return to their reset values;
  - the first valid output appears 2 cycles after the first in_valid following deassertion.

## Test plan
- **Reset defaults, solid bands.** Transparent index 0x10 at y=299 gives 0x000. y=400 gives 0x007. y=1023 gives 0x007 (DEFAULT path). Each out_valid appears exactly 2 cycles after in_valid.
- **Opaque passthrough and bypass.** index 0x123 at y=50 gives 0x123. With enable=0, index 0x010 at y=50 gives 0x010.
- **Pattern band with scroll.**
  - Setup: write texel {row 3, col 5} = 6. Set CTRL[1] = {1, 0x020}. Set SCROLL[1] = 1.
  - Stimulus: transparent pixel at x=4, y=303.
  - Required: output 0x026.
  - Setup: set SCROLL[1] = 1023.
  - Stimulus: pixel at x=6.
  - Required: the same texel is read, through scroll wrap-around.
- **Priority and config timing.**
  - Write END[0]=500 and issue a y=350 transparent pixel on the next cycle: the output is COLOR[0].
  - A pixel issued on the same edge as that write still selects band 1.
- **Back-to-back stream with bubbles.** 64 pixels with a random in_valid pattern: the output sequence matches a reference model, and out_valid equals in_valid delayed by 2.
- **Mid-stream reset.** Assert rst_n=0 with both stages full: out_valid and index_out go to 0 without a clock edge. After release, END[0] reads back as 300, and no stale pixel emerges.
